apb_protocol_checker: RTL and testbench

APB_PROTOCOL_CHECKER -- requirements
Module: apb_protocol_checker

---
 rtl/apb_chk_pkg.sv | 20 ++
 rtl/apb_protocol_checker.sv | 157 +++++++++++++++
 tb/tb_apb_protocol_checker.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_chk_pkg.sv
// Shared constants for the APB protocol checker: error vector width, error bit
// positions and the observer FSM state encoding.
package apb_chk_pkg;

  localparam int ERR_W = 6;

  localparam int ERR_ACCESS_NO_SETUP = 0;
  localparam int ERR_SETUP_NO_ACCESS = 1;
  localparam int ERR_UNSTABLE        = 2;
  localparam int ERR_MULTI_SEL       = 3;
  localparam int ERR_STRB_ON_READ    = 4;
  localparam int ERR_TIMEOUT         = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/apb_protocol_checker.sv
// Passive APB observer: flags protocol violations and collects transfer statistics.
// Optional wait-state timeout enabled by defining APB_CHK_TIMEOUT_EN.
module apb_protocol_checker
  import apb_chk_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 1,
  parameter int TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic [NUM_SLV-1:0]  PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic                PREADY,
  input  logic                PSLVERR,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  input  logic                clr_i,
  output logic                err_valid,
  output logic [ERR_W-1:0]    err_code,
  output logic [ERR_W-1:0]    err_sticky,
  output logic [15:0]         xfer_cnt,
  output logic [15:0]         slverr_cnt,
  output logic [7:0]          wait_max
);

  if (TIMEOUT < 2 || TIMEOUT > 255 || (DATA_W % 8) != 0) begin : g_bad_cfg
    $error("apb_protocol_checker: TIMEOUT must be 2..255 and DATA_W a multiple of 8");
  end

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t                state, state_nxt;
  logic [NUM_SLV-1:0]    cap_sel;
  logic [ADDR_W-1:0]     cap_addr;
  logic                  cap_write;
  logic [DATA_W-1:0]     cap_wdata;
  logic [DATA_W/8-1:0]   cap_strb;
  logic [7:0]            wait_cnt, wait_nxt, done_waits;
  logic                  capture, done;
  logic                  any_sel, multi_sel, sel_changed, unstable, broken;
  logic [ERR_W-1:0]      viol;

  assign any_sel     = |PSEL;
  assign multi_sel   = (PSEL & (PSEL - NUM_SLV'(1))) != '0;
  assign sel_changed = PSEL != cap_sel;
  assign broken      = !PENABLE || sel_changed;
  assign unstable    = (PADDR != cap_addr) || (PWRITE != cap_write) ||
                       (PWDATA != cap_wdata) || (PSTRB != cap_strb);

  always_comb begin
    viol       = '0;
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    done_waits = wait_cnt;
    capture    = 1'b0;
    done       = 1'b0;
    viol[ERR_MULTI_SEL] = multi_sel;
    case (state)
      ST_IDLE: begin
        if (any_sel) begin
          if (PENABLE) begin
            viol[ERR_ACCESS_NO_SETUP] = 1'b1;
          end else begin
            capture   = 1'b1;
            wait_nxt  = 8'd0;
            state_nxt = ST_SETUP;
            viol[ERR_STRB_ON_READ] = !PWRITE && (|PSTRB);
          end
        end
      end
      ST_SETUP: begin
        viol[ERR_SETUP_NO_ACCESS] = broken;
        viol[ERR_UNSTABLE]        = unstable;
        if (broken || unstable) begin
          state_nxt = ST_IDLE;
        end else if (PREADY) begin
          done       = 1'b1;
          done_waits = 8'd0;
          state_nxt  = ST_IDLE;
        end else begin
          wait_nxt  = 8'd1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // In the wait phase a dropped PENABLE or PSEL is a stability fault.
        viol[ERR_UNSTABLE] = broken || unstable;
        if (broken || unstable) begin
          state_nxt = ST_IDLE;
        end else if (PREADY) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          wait_nxt = sat_inc8(wait_cnt);
`ifdef APB_CHK_TIMEOUT_EN
          if (int'(wait_nxt) >= TIMEOUT) begin
            viol[ERR_TIMEOUT] = 1'b1;
            state_nxt         = ST_IDLE;
          end
`endif
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
`ifndef APB_CHK_TIMEOUT_EN
    viol[ERR_TIMEOUT] = 1'b0;
`endif
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      cap_sel    <= '0;
      cap_addr   <= '0;
      cap_write  <= 1'b0;
      cap_wdata  <= '0;
      cap_strb   <= '0;
      err_valid  <= 1'b0;
      err_code   <= '0;
      err_sticky <= '0;
      xfer_cnt   <= '0;
      slverr_cnt <= '0;
      wait_max   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (capture) begin
        cap_sel   <= PSEL;
        cap_addr  <= PADDR;
        cap_write <= PWRITE;
        cap_wdata <= PWDATA;
        cap_strb  <= PSTRB;
      end
      err_valid  <= |viol;
      err_code   <= viol;
      // A violation seen in the clearing cycle survives the clear.
      err_sticky <= (clr_i ? '0 : err_sticky) | viol;
      if (done) begin
        xfer_cnt <= sat_inc16(xfer_cnt);
        if (PSLVERR) slverr_cnt <= sat_inc16(slverr_cnt);
        if (done_waits > wait_max) wait_max <= done_waits;
      end
    end
  end

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Directed bench for apb_protocol_checker with a transfer-level reference model
// compared against the DUT outputs on every falling clock edge.
module tb_apb_protocol_checker;

`ifdef APB_CHK_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  psel;
  logic        penable, pwrite, pready, pslverr, clr;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        err_valid;
  logic [5:0]  err_code, err_sticky;
  logic [15:0] xfer_cnt, slverr_cnt;
  logic [7:0]  wait_max;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  apb_protocol_checker #(
    .ADDR_W(8), .DATA_W(32), .NUM_SLV(2), .TIMEOUT(TMO)
  ) dut (
    .PCLK(clk), .PRESET(rst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PREADY(pready), .PSLVERR(pslverr), .PADDR(paddr), .PWDATA(pwdata),
    .PSTRB(pstrb), .clr_i(clr), .err_valid(err_valid), .err_code(err_code),
    .err_sticky(err_sticky), .xfer_cnt(xfer_cnt), .slverr_cnt(slverr_cnt),
    .wait_max(wait_max)
  );

  // Reference model: a transfer is "open" after a setup phase; acc counts
  // access cycles seen with PREADY low, which is exactly its wait-state count.
  bit          m_open;
  int          m_acc;
  logic [1:0]  c_sel;
  logic [7:0]  c_addr;
  logic        c_wr;
  logic [31:0] c_wd;
  logic [3:0]  c_strb;
  logic [5:0]  code;
  bit          m_valid;
  logic [5:0]  m_code, m_sticky;
  int          m_xfer, m_serr, m_wmax;
  bit          broke, moved;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_open = 0; m_acc = 0; c_sel = 0; c_addr = 0; c_wr = 0; c_wd = 0; c_strb = 0;
      m_valid = 0; m_code = 0; m_sticky = 0; m_xfer = 0; m_serr = 0; m_wmax = 0;
    end else begin
      code = 0;
      if ($countones(psel) > 1) code[3] = 1;
      if (!m_open) begin
        if (psel != 0) begin
          if (penable) code[0] = 1;
          else begin
            m_open = 1; m_acc = 0;
            c_sel = psel; c_addr = paddr; c_wr = pwrite; c_wd = pwdata; c_strb = pstrb;
            if (!pwrite && pstrb != 0) code[4] = 1;
          end
        end
      end else begin
        broke = !penable || psel != c_sel;
        moved = paddr != c_addr || pwrite != c_wr || pwdata != c_wd || pstrb != c_strb;
        if (m_acc == 0 && broke) code[1] = 1;
        if (moved || (m_acc > 0 && broke)) code[2] = 1;
        if (broke || moved) m_open = 0;
        else if (pready) begin
          m_open = 0;
          m_xfer = (m_xfer < 65535) ? m_xfer + 1 : 65535;
          if (pslverr) m_serr = (m_serr < 65535) ? m_serr + 1 : 65535;
          if (m_acc > m_wmax) m_wmax = m_acc;
        end else begin
          m_acc = (m_acc < 255) ? m_acc + 1 : 255;
`ifdef APB_CHK_TIMEOUT_EN
          if (m_acc >= TMO) begin code[5] = 1; m_open = 0; end
`endif
        end
      end
      m_valid  = code != 0;
      m_code   = code;
      m_sticky = (clr ? 6'd0 : m_sticky) | code;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("err_valid",  32'(err_valid),  32'(m_valid));
    check("err_code",   32'(err_code),   32'(m_code));
    check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    check("xfer_cnt",   32'(xfer_cnt),   32'(m_xfer));
    check("slverr_cnt", 32'(slverr_cnt), 32'(m_serr));
    check("wait_max",   32'(wait_max),   32'(m_wmax));
  end

  // Called right after a falling edge; drives one bus cycle.
  task automatic cyc(input logic [1:0] sel, input logic en, input logic wr, input logic rdy,
                     input logic serr, input logic [7:0] addr, input logic [3:0] strb);
    psel = sel; penable = en; pwrite = wr; pready = rdy; pslverr = serr;
    paddr = addr; pstrb = strb;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(2'b00, 0, 0, 0, 0, 8'h00, 4'h0);
  endtask

  task automatic xfer(input logic [1:0] sel, input logic wr, input logic [7:0] addr,
                      input logic [3:0] strb, input int waits, input logic serr);
    pwdata = 32'hA5A5_0000 | 32'(addr);
    cyc(sel, 0, wr, 0, 0, addr, strb);
    for (int i = 0; i < waits; i++) cyc(sel, 1, wr, 0, 0, addr, strb);
    cyc(sel, 1, wr, 1, serr, addr, strb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 0; pwdata = 0;
    psel = 0; penable = 0; pwrite = 0; pready = 0; pslverr = 0; paddr = 0; pstrb = 0;
    repeat (2) @(negedge clk);
    check("reset_err_valid", 32'(err_valid), 0);
    check("reset_xfer_cnt",  32'(xfer_cnt),  0);
    rst = 1'b0;
    idle();

    // Write to 0x10 with two wait states.
    xfer(2'b01, 1, 8'h10, 4'hF, 2, 0);
    check("wr_xfer_cnt", 32'(xfer_cnt), 1);
    check("wr_wait_max", 32'(wait_max), 2);
    check("wr_sticky",   32'(err_sticky), 0);

    // Back-to-back transfers, second on the other slave.
    xfer(2'b01, 0, 8'h20, 4'h0, 0, 0);
    xfer(2'b10, 0, 8'h24, 4'h0, 1, 0);
    idle();
    check("b2b_xfer_cnt", 32'(xfer_cnt), 3);
    check("b2b_sticky",   32'(err_sticky), 0);

    // Setup phase not followed by an access phase.
    cyc(2'b01, 0, 1, 0, 0, 8'h10, 4'hF);
    cyc(2'b01, 0, 1, 0, 0, 8'h10, 4'hF);
    check("noacc_valid", 32'(err_valid), 1);
    check("noacc_code",  32'(err_code), 32'h02);
    idle();
    check("noacc_pulse_end", 32'(err_valid), 0);

    // Address change during the wait phase.
    cyc(2'b01, 0, 1, 0, 0, 8'h10, 4'hF);
    cyc(2'b01, 1, 1, 0, 0, 8'h10, 4'hF);
    cyc(2'b01, 1, 1, 0, 0, 8'h14, 4'hF);
    check("unstable_code", 32'(err_code), 32'h04);
    idle();

    // Two slaves selected at once.
    cyc(2'b11, 0, 1, 0, 0, 8'h18, 4'hF);
    check("multisel_bit", 32'(err_code[3]), 1);
    cyc(2'b11, 1, 1, 1, 0, 8'h18, 4'hF);
    clr = 1;
    idle();
    clr = 0;
    check("clr_sticky", 32'(err_sticky), 0);

    // Read with strobes and a slave error.
    cyc(2'b01, 0, 0, 0, 0, 8'h1C, 4'hF);
    check("strb_read_code", 32'(err_code), 32'h10);
    cyc(2'b01, 1, 0, 1, 1, 8'h1C, 4'hF);
    check("slverr_cnt", 32'(slverr_cnt), 1);
    clr = 1;
    cyc(2'b01, 1, 0, 0, 0, 8'h1C, 4'hF);
    clr = 0;
    check("clr_keeps_new", 32'(err_sticky), 32'h01);
    idle();

    // Long wait: 20 wait states (times out when the timeout is enabled).
    xfer(2'b01, 1, 8'h30, 4'hF, 20, 0);
    idle();
`ifndef APB_CHK_TIMEOUT_EN
    check("long_wait_max", 32'(wait_max), 20);
`endif

    // Reset asserted mid-transfer clears everything without waiting for a clock.
    cyc(2'b01, 0, 1, 0, 0, 8'h40, 4'hF);
    cyc(2'b01, 1, 1, 0, 0, 8'h40, 4'hF);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_xfer_cnt", 32'(xfer_cnt), 0);
    check("async_sticky",   32'(err_sticky), 0);
    check("async_wait_max", 32'(wait_max), 0);
    check("async_slverr",   32'(slverr_cnt), 0);
    @(negedge clk);
    psel = 0; penable = 0; pready = 0;
    rst = 1'b0;
    idle();
    xfer(2'b01, 1, 8'h44, 4'hF, 1, 0);
    idle();
    check("post_rst_xfer", 32'(xfer_cnt), 1);
    check("post_rst_sticky", 32'(err_sticky), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
